// File: rtl/ctl_ammo.sv
// Magazine tracker for Duck Hunt: shot qualification, ammo count, timed reload.
// Optional AMMO_AUTO_RELOAD_EN: the emptying shot starts a reload directly.
module ctl_ammo #(
  parameter int MAG_SIZE      = 3,
  parameter int CNT_W         = 2,
  parameter int RELOAD_CYCLES = 32_500_000,
  parameter int TMR_W         = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             reload_req,
  input  logic             new_round,
  input  logic             pause,
  output logic             shot,
  output logic [CNT_W-1:0] ammo,
  output logic             reloading,
  output logic             no_ammo
);

  typedef enum logic [1:0] {
    READY,
    EMPTY,
    RELOAD
  } state_t;

  localparam logic [CNT_W-1:0] FULL  = CNT_W'(MAG_SIZE);
  localparam logic [TMR_W-1:0] TLOAD = TMR_W'(RELOAD_CYCLES - 1);

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] ammo_n;
  logic             shot_n, reloading_n, no_ammo_n;
  logic             trigger_q, reload_q;
  logic             trig_evt, rl_evt;

  assign trig_evt = trigger & ~trigger_q;
  assign rl_evt   = reload_req & ~reload_q;

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    ammo_n      = ammo;
    shot_n      = 1'b0;
    reloading_n = reloading;
    no_ammo_n   = no_ammo;
    if (new_round) begin
      state_n     = READY;
      timer_n     = '0;
      ammo_n      = FULL;
      reloading_n = 1'b0;
      no_ammo_n   = 1'b0;
    end else begin
      unique case (state)
        READY: begin
          if (trig_evt && !pause && ammo != '0) begin
            shot_n = 1'b1;
            ammo_n = ammo - CNT_W'(1);
            if (ammo == CNT_W'(1)) begin
              no_ammo_n = 1'b1;
`ifdef AMMO_AUTO_RELOAD_EN
              state_n     = RELOAD;
              timer_n     = TLOAD;
              reloading_n = 1'b1;
`else
              state_n = EMPTY;
`endif
            end
          end else if (rl_evt && !pause && ammo < FULL) begin
            state_n     = RELOAD;
            timer_n     = TLOAD;
            reloading_n = 1'b1;
          end
        end
        EMPTY: begin
          if (rl_evt && !pause) begin
            state_n     = RELOAD;
            timer_n     = TLOAD;
            reloading_n = 1'b1;
          end
        end
        RELOAD: begin
          // Timer freezes while paused; refill only on an unpaused zero.
          if (!pause) begin
            if (timer == '0) begin
              state_n     = READY;
              ammo_n      = FULL;
              reloading_n = 1'b0;
              no_ammo_n   = 1'b0;
            end else begin
              timer_n = timer - TMR_W'(1);
            end
          end
        end
        default: state_n = READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= READY;
      timer     <= '0;
      ammo      <= FULL;
      shot      <= 1'b0;
      reloading <= 1'b0;
      no_ammo   <= 1'b0;
      // Held levels through reset must not look like fresh edges.
      trigger_q <= 1'b1;
      reload_q  <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      ammo      <= ammo_n;
      shot      <= shot_n;
      reloading <= reloading_n;
      no_ammo   <= no_ammo_n;
      trigger_q <= trigger;
      reload_q  <= reload_req;
    end
  end

endmodule

// File: tb/tb_ctl_ammo.sv
// Scoreboard bench for ctl_ammo (MAG_SIZE=3, RELOAD_CYCLES=8).
module tb_ctl_ammo;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger, reload_req, new_round, pause;
  logic       shot, reloading, no_ammo;
  logic [1:0] ammo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       shot;
    logic [1:0] ammo;
    logic       rel;
    logic       na;
    string      name;
  } exp_t;

  exp_t q[$];

  ctl_ammo #(
    .MAG_SIZE(3),
    .CNT_W(2),
    .RELOAD_CYCLES(8),
    .TMR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .reload_req(reload_req),
    .new_round(new_round),
    .pause(pause),
    .shot(shot),
    .ammo(ammo),
    .reloading(reloading),
    .no_ammo(no_ammo)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs; expected outputs after the next edge.
  task automatic step(input logic t, input logic r, input logic n,
                      input logic p, input logic es, input int ea,
                      input logic er, input logic en, input string nm);
    exp_t e;
    trigger    = t;
    reload_req = r;
    new_round  = n;
    pause      = p;
    e.shot = es;
    e.ammo = 2'(ea);
    e.rel  = er;
    e.na   = en;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        checks++;
        if (shot !== e.shot || ammo !== e.ammo ||
            reloading !== e.rel || no_ammo !== e.na) begin
          errors++;
          $display("FAIL %s: got shot=%b ammo=%0d rel=%b na=%b, want shot=%b ammo=%0d rel=%b na=%b",
                   e.name, shot, ammo, reloading, no_ammo,
                   e.shot, e.ammo, e.rel, e.na);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b0;
    trigger = 1'b1;
    reload_req = 1'b0;
    new_round = 1'b0;
    pause = 1'b0;
    step(1, 0, 0, 0, 0, 3, 0, 0, "rst_vals");
    step(1, 0, 0, 0, 0, 3, 0, 0, "rst_vals2");
    rst = 1'b1;
    step(1, 0, 0, 0, 0, 3, 0, 0, "held_trig");
    step(0, 0, 0, 0, 0, 3, 0, 0, "release");
    step(1, 0, 0, 0, 1, 2, 0, 0, "shot1");
    step(1, 0, 0, 0, 0, 2, 0, 0, "shot1_once");
    step(0, 0, 0, 0, 0, 2, 0, 0, "rel1");
    step(1, 0, 0, 0, 1, 1, 0, 0, "shot2");
    step(0, 0, 0, 0, 0, 1, 0, 0, "rel2");
`ifdef AMMO_AUTO_RELOAD_EN
    step(1, 0, 0, 0, 1, 0, 1, 1, "shot3_auto");
    step(0, 0, 0, 0, 0, 0, 1, 1, "auto_t6");
    step(1, 0, 0, 0, 0, 0, 1, 1, "auto_noshot");
    step(0, 0, 0, 0, 0, 0, 1, 1, "auto_t4");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 0, 1, 1, "auto_wait");
    step(0, 0, 0, 0, 0, 3, 0, 0, "auto_refill");
`else
    step(1, 0, 0, 0, 1, 0, 0, 1, "shot3_empty");
    step(0, 0, 0, 0, 0, 0, 0, 1, "empty_hold");
    step(1, 0, 0, 0, 0, 0, 0, 1, "empty_noshot");
    step(0, 0, 0, 0, 0, 0, 0, 1, "empty_hold2");
    step(0, 1, 0, 0, 0, 0, 1, 1, "rl_start");
    for (int i = 0; i < 7; i++)
      step(0, 0, 0, 0, 0, 0, 1, 1, "rl_wait");
    step(0, 0, 0, 0, 0, 3, 0, 0, "rl_refill");
`endif
    // paused reload from a partial magazine
    step(1, 0, 0, 0, 1, 2, 0, 0, "p_shot");
    step(0, 0, 0, 0, 0, 2, 0, 0, "p_rel");
    step(0, 1, 0, 0, 0, 2, 1, 0, "p_rl_start");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 2, 1, 0, "p_run");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 1, 0, 2, 1, 0, "p_hold");
    step(1, 0, 0, 0, 0, 2, 1, 0, "p_trig_ign");
    step(0, 0, 0, 0, 0, 2, 1, 0, "p_run2");
    step(0, 0, 0, 0, 0, 2, 1, 0, "p_run2");
    step(0, 0, 0, 0, 0, 2, 1, 0, "p_run2");
    step(0, 0, 0, 0, 0, 3, 0, 0, "p_refill");
    // edges during pause are discarded, not deferred
    step(0, 0, 0, 1, 0, 3, 0, 0, "pz_idle");
    step(1, 0, 0, 1, 0, 3, 0, 0, "pz_trig");
    step(1, 0, 0, 0, 0, 3, 0, 0, "pz_nodefer");
    step(0, 0, 0, 0, 0, 3, 0, 0, "pz_rel");
    step(0, 1, 0, 0, 0, 3, 0, 0, "rl_full_ign");
    step(0, 0, 0, 0, 0, 3, 0, 0, "rl_full_rel");
    // simultaneous events
    step(1, 0, 0, 0, 1, 2, 0, 0, "s_shot");
    step(0, 0, 0, 0, 0, 2, 0, 0, "s_rel");
    step(1, 1, 0, 0, 1, 1, 0, 0, "s_both");
    step(0, 0, 0, 0, 0, 1, 0, 0, "s_noreload");
    step(1, 0, 1, 0, 0, 3, 0, 0, "nr_trig");
    step(0, 0, 0, 0, 0, 3, 0, 0, "nr_after");
    // new_round aborts a reload even while paused
    step(1, 0, 0, 0, 1, 2, 0, 0, "nr_shot");
    step(0, 0, 0, 0, 0, 2, 0, 0, "nr_rel");
    step(0, 1, 0, 0, 0, 2, 1, 0, "nr_rl");
    step(0, 0, 1, 1, 0, 3, 0, 0, "nr_paused");
    step(0, 0, 0, 0, 0, 3, 0, 0, "nr_ready");
    // reset mid-reload
    step(1, 0, 0, 0, 1, 2, 0, 0, "rr_shot");
    step(0, 0, 0, 0, 0, 2, 0, 0, "rr_rel");
    step(0, 1, 0, 0, 0, 2, 1, 0, "rr_rl");
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 3, 0, 0, "rr_reset");
    rst = 1'b1;
    step(0, 1, 0, 0, 0, 3, 0, 0, "rr_held");
    step(0, 0, 0, 0, 0, 3, 0, 0, "rr_idle");
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctl_ammo.md
Name: ctl_ammo

Overview:
Tracks the player's magazine for the Duck Hunt game and sits directly upstream of the pause controller. It qualifies raw trigger presses into single-cycle shot pulses and decrements the ammo count on each shot. It runs a timed reload sequence and drives the registered no_ammo flag that the pause controller consumes. Shot pulses also feed the hit-detection logic downstream.

Parameters:
MAG_SIZE, 3, rounds per full magazine (1..2**CNT_W-1)
CNT_W, 2, width of ammo count
RELOAD_CYCLES, 32_500_000, clock cycles a reload takes (0.5 s at 65 MHz); at least 2
TMR_W, 25, width of reload timer; must hold RELOAD_CYCLES-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (reset when rst==0)
trigger  in  1  gun trigger level, already synchronised to clk
reload_req  in  1  reload button level, synchronised
new_round  in  1  one-cycle pulse: refill magazine at start of round
pause  in  1  game paused (registered output of pause controller)
shot  out  1  one-cycle pulse per accepted shot
ammo  out  CNT_W  rounds remaining
reloading  out  1  high while reload timer runs
no_ammo  out  1  registered, ammo==0

Behaviour:
- All outputs registered. Reset values:
  - ammo=MAG_SIZE, shot=0, reloading=0, no_ammo=0.
  - FSM in READY; timer=0.
  - Edge-detect registers for trigger and reload_req reset to 1, so a level held through reset produces no event.
- Events:
  - trig_evt = trigger & ~trigger_q (rising edge).
  - rl_evt = reload_req & ~reload_q.
- Pause behaviour: while pause=1, edges are consumed and discarded, never deferred.
- FSM states: READY, EMPTY, RELOAD.
- READY:
  - trig_evt & ~pause: shot=1 next cycle; ammo decrements.
    - If ammo was 1: go to EMPTY, and no_ammo rises on the same edge that ammo reaches 0.
  - rl_evt & ~pause & ammo<MAG_SIZE: go to RELOAD; timer loads RELOAD_CYCLES-1; reloading=1 next cycle.
  - rl_evt with a full magazine: ignored.
  - trig_evt and rl_evt in the same cycle: the shot wins and the reload is dropped.
- EMPTY:
  - ammo=0, no_ammo=1.
  - trig_evt gives no shot.
  - rl_evt & ~pause: go to RELOAD.
- RELOAD:
  - trig_evt is ignored; no shot.
  - Timer decrements once per cycle while pause=0 and holds while pause=1.
  - When timer==0 and pause=0: ammo=MAG_SIZE, no_ammo=0, reloading=0, go to READY.
  - Latency from the accepting rl_evt edge to ammo refill: exactly RELOAD_CYCLES+1 unpaused cycles.
- new_round, highest priority:
  - From any state: ammo=MAG_SIZE, no_ammo=0, reloading=0, timer=0, go to READY, next cycle.
  - A same-cycle trig_evt is discarded.
  - Acts even while pause=1.
- shot is high for exactly one cycle per accepted event; never two consecutive cycles from one press.
- Ammo never wraps below 0 or above MAG_SIZE.
- Reset mid-reload aborts the reload and restores the reset values above.

Optional Feature:
Macro AMMO_AUTO_RELOAD_EN.
- Defined: the shot that empties the magazine moves the FSM straight to RELOAD, with the timer loaded and reloading=1 on the same edge that ammo reaches 0. EMPTY is unreachable, and no_ammo stays 1 until the refill.
- Undefined: behaviour as above; the player must press reload from EMPTY.

Test Plan:
(Sim parameters: MAG_SIZE=3, RELOAD_CYCLES=8.)
- Reset:
  - Stimulus: release rst with trigger held 1.
  - Required: ammo=3, no_ammo=0, no shot pulse; releasing then pressing trigger gives one shot and ammo=2.
- Empty magazine:
  - Stimulus: three separate trigger presses, then a fourth.
  - Required: three 1-cycle shot pulses, ammo 3→2→1→0, no_ammo=1 in the cycle ammo hits 0; fourth press gives no shot, ammo stays 0.
- Reload timing:
  - Stimulus: reload_req rising edge in EMPTY.
  - Required: reloading=1 for 8 cycles; ammo=3, no_ammo=0 exactly 9 cycles after the edge.
- Pause during reload:
  - Stimulus: pause=1 for 5 cycles mid-reload.
  - Required: refill delayed by exactly 5 cycles; trigger edges while paused in READY give no shot and no decrement.
- Simultaneous events:
  - Stimulus: trigger and reload edges in the same cycle at ammo=2.
  - Required: shot=1, ammo=1, no reload started.
  - Stimulus: new_round together with a trigger edge.
  - Required: ammo=3, no shot.
- AMMO_AUTO_RELOAD_EN defined:
  - Stimulus: three shots.
  - Required: reloading=1 on the same edge ammo=0; ammo=3 nine cycles later with no reload_req.
